survivor_memory: RTL and testbench

SURVIVOR_MEMORY -- requirements
Module: survivor_memory

---
 rtl/survivor_memory.sv | 153 +++++++++++++++
 tb/tb_survivor_memory.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/survivor_memory.sv
// -----------------------------------------------------------------------------
// survivor_memory
//
// Ring buffer of Viterbi survivor decisions. Each accepted ACS decision vector
// (2^M bits, one per trellis state) is written into the next column of a
// D-column ring. A fill counter tracks how many columns hold valid history
// in the current frame. Once the ring is full, every further write issues a
// one-cycle traceback request. The traceback unit reads single bits
// (column tb_time, state tb_state) with a one-cycle registered latency.
//
// Ports
//   clk          in   sole clock, rising edge
//   rst          in   synchronous active-high reset
//   dec_valid    in   decision vector valid this cycle
//   dec_vec      in   [2^M]        survivor decisions, bit s = state s
//   frame_start  in   start a new frame, discard history
//   wr_ptr       out  [clog2(D)]   most recently written column
//   fill         out  [clog2(D+1)] valid column count, saturates at D
//   full         out  fill == D
//   tb_req       out  one-cycle traceback-start pulse
//   tb_time      in   [clog2(D)]   traceback read column
//   tb_state     in   [M]          traceback read state
//   tb_surv_bit  out  registered survivor bit
//
// Build option
//   SURVMEM_RAW_FWD_EN : when defined, a read that hits the column being
//   written in the same cycle returns the new bit instead of the old content.
// -----------------------------------------------------------------------------
module survivor_memory #(
    parameter int M = 6,
    parameter int D = 40,
    localparam int NS     = 1 << M,
    localparam int PTR_W  = $clog2(D),
    localparam int FILL_W = $clog2(D + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dec_valid,
    input  logic [NS-1:0]     dec_vec,
    input  logic              frame_start,
    output logic [PTR_W-1:0]  wr_ptr,
    output logic [FILL_W-1:0] fill,
    output logic              full,
    output logic              tb_req,
    input  logic [PTR_W-1:0]  tb_time,
    input  logic [M-1:0]      tb_state,
    output logic              tb_surv_bit
);

    localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(D - 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(D);
    localparam logic [PTR_W:0]    DEPTH_X  = (PTR_W + 1)'(D);

    // Survivor storage; deliberately not reset (validity is tracked by fill).
    logic [NS-1:0]     mem_q [D];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              tb_req_q, tb_req_d;
    logic              surv_q, surv_d;
    logic [PTR_W-1:0]  wr_col_s;
    logic              mem_we_s;
    logic              rd_in_range_s;

    // Write column: frame_start restarts the ring at column 0, otherwise advance with wrap.
    always_comb begin
        if (frame_start) begin
            wr_col_s = '0;
        end else if (wr_ptr_q == PTR_LAST) begin
            wr_col_s = '0;
        end else begin
            wr_col_s = wr_ptr_q + PTR_W'(1);
        end
    end

    // Reset has priority over writes, so a write in a reset cycle is dropped.
    assign mem_we_s      = dec_valid & ~rst;
    assign rd_in_range_s = ({1'b0, tb_time} < DEPTH_X);

    // Next-state for pointer, fill and traceback request.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        fill_d   = fill_q;
        tb_req_d = 1'b0;
        if (dec_valid) begin
            wr_ptr_d = wr_col_s;
            if (frame_start) begin
                fill_d = FILL_W'(1);
            end else if (fill_q < FILL_MAX) begin
                fill_d = fill_q + FILL_W'(1);
            end else begin
                fill_d = fill_q;
            end
            // A pulse follows every write that leaves the ring full.
            tb_req_d = (fill_d == FILL_MAX);
        end else if (frame_start) begin
            wr_ptr_d = PTR_LAST;
            fill_d   = '0;
            tb_req_d = 1'b0;
        end else begin
            wr_ptr_d = wr_ptr_q;
            fill_d   = fill_q;
            tb_req_d = 1'b0;
        end
    end

    // Read mux: out-of-range columns return 0; optional same-cycle write forwarding.
    always_comb begin
        surv_d = 1'b0;
        if (rd_in_range_s) begin
`ifdef SURVMEM_RAW_FWD_EN
            if (mem_we_s && (wr_col_s == tb_time)) begin
                surv_d = dec_vec[tb_state];
            end else begin
                surv_d = mem_q[tb_time][tb_state];
            end
`else
            surv_d = mem_q[tb_time][tb_state];
`endif
        end else begin
            surv_d = 1'b0;
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[wr_col_s] <= dec_vec;
        end
    end

    // Control and read-data registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= PTR_LAST;
            fill_q   <= '0;
            tb_req_q <= 1'b0;
            surv_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            fill_q   <= fill_d;
            tb_req_q <= tb_req_d;
            surv_q   <= surv_d;
        end
    end

    assign wr_ptr      = wr_ptr_q;
    assign fill        = fill_q;
    assign full        = (fill_q == FILL_MAX);
    assign tb_req      = tb_req_q;
    assign tb_surv_bit = surv_q;

endmodule

// File: tb/tb_survivor_memory.sv
// Scoreboard bench for survivor_memory: stimulus task pushes expected outputs
// computed by a behavioural ring model; a monitor pops one entry per clock.
module tb_survivor_memory;

    localparam int M  = 6;
    localparam int D  = 40;
    localparam int NS = 64;
    localparam int PW = 6;
    localparam int FW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          dec_valid;
    logic [NS-1:0] dec_vec;
    logic          frame_start;
    logic [PW-1:0] wr_ptr;
    logic [FW-1:0] fill;
    logic          full;
    logic          tb_req;
    logic [PW-1:0] tb_time;
    logic [M-1:0]  tb_state;
    logic          tb_surv_bit;

    always #5 clk = ~clk;

    survivor_memory #(.M(M), .D(D)) dut (
        .clk         (clk),
        .rst         (rst),
        .dec_valid   (dec_valid),
        .dec_vec     (dec_vec),
        .frame_start (frame_start),
        .wr_ptr      (wr_ptr),
        .fill        (fill),
        .full        (full),
        .tb_req      (tb_req),
        .tb_time     (tb_time),
        .tb_state    (tb_state),
        .tb_surv_bit (tb_surv_bit)
    );

    typedef struct {
        int ptr;
        int fill;
        int full;
        int req;
        int surv;
        bit surv_chk;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: plain ring of columns plus "ever written" flags.
    logic [NS-1:0] m_mem [D];
    bit            m_known [D];
    int            m_ptr  = D - 1;
    int            m_fill = 0;

    task automatic cmp(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // One clock of stimulus; called at a negative edge.
    task automatic step(input bit r, input bit dv, input logic [NS-1:0] vec,
                        input bit fs, input int tt, input int ts);
        exp_t e;
        int   col;
        rst         = r;
        dec_valid   = dv;
        dec_vec     = vec;
        frame_start = fs;
        tb_time     = tt[PW-1:0];
        tb_state    = ts[M-1:0];
        e.req = 0;
        e.surv = 0;
        e.surv_chk = 1'b1;
        if (r) begin
            m_ptr  = D - 1;
            m_fill = 0;
        end else begin
            col = fs ? 0 : ((m_ptr + 1) % D);
            if (tt >= D) begin
                e.surv = 0;
            end else if (dv && col == tt) begin
`ifdef SURVMEM_RAW_FWD_EN
                e.surv = int'(vec[ts]);
`else
                e.surv     = int'(m_mem[tt][ts]);
                e.surv_chk = m_known[tt];
`endif
            end else begin
                e.surv     = int'(m_mem[tt][ts]);
                e.surv_chk = m_known[tt];
            end
            if (dv) begin
                m_mem[col]   = vec;
                m_known[col] = 1'b1;
                m_ptr        = col;
                m_fill       = fs ? 1 : ((m_fill < D) ? m_fill + 1 : D);
                e.req        = (m_fill == D) ? 1 : 0;
            end else if (fs) begin
                m_ptr  = D - 1;
                m_fill = 0;
            end
        end
        e.ptr  = m_ptr;
        e.fill = m_fill;
        e.full = (m_fill == D) ? 1 : 0;
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    function automatic logic [NS-1:0] rvec();
        return {$urandom, $urandom};
    endfunction

    // Monitor: every clock the DUT presents new registered outputs; compare one entry.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                cmp("wr_ptr", int'(wr_ptr), e.ptr);
                cmp("fill", int'(fill), e.fill);
                cmp("full", int'(full), e.full);
                cmp("tb_req", int'(tb_req), e.req);
                if (e.surv_chk) cmp("tb_surv_bit", int'(tb_surv_bit), e.surv);
            end
        end
    end

    initial begin
        logic [NS-1:0] v;
        for (int i = 0; i < D; i++) m_known[i] = 1'b0;
        rst = 1'b1; dec_valid = 1'b0; dec_vec = '0; frame_start = 1'b0;
        tb_time = '0; tb_state = '0;
        @(negedge clk);

        // Reset, then three writes.
        step(1, 0, '0, 0, 0, 0);
        step(1, 1, rvec(), 0, 0, 0);
        cmp("rst_ptr", int'(wr_ptr), 39);
        cmp("rst_fill", int'(fill), 0);
        v = 64'h1; step(0, 1, v, 0, 0, 0);
        cmp("w1_ptr", int'(wr_ptr), 0);
        v = 64'h2; step(0, 1, v, 0, 0, 0);
        cmp("w2_ptr", int'(wr_ptr), 1);
        v = 64'h4; step(0, 1, v, 0, 0, 0);
        cmp("w3_ptr", int'(wr_ptr), 2);
        cmp("w3_fill", int'(fill), 3);
        cmp("w3_full", int'(full), 0);

        // Column 5 with only bit 17 set, then bit reads.
        step(0, 1, rvec(), 0, 1, 0);
        step(0, 1, rvec(), 0, 2, 2);
        v = 64'h0000_0000_0002_0000; step(0, 1, v, 0, 0, 0);
        cmp("col5_ptr", int'(wr_ptr), 5);
        step(0, 0, '0, 0, 5, 17);
        cmp("rd_5_17", int'(tb_surv_bit), 1);
        step(0, 0, '0, 0, 5, 16);
        cmp("rd_5_16", int'(tb_surv_bit), 0);
        step(0, 0, '0, 0, 45, 17);
        cmp("rd_oor", int'(tb_surv_bit), 0);

        // Fill the ring: 40 writes, tb_req after the 40th, then a 41st.
        step(1, 0, '0, 0, 0, 0);
        for (int i = 0; i < D; i++) step(0, 1, rvec(), 0, 0, 0);
        cmp("full_fill", int'(fill), 40);
        cmp("full_full", int'(full), 1);
        cmp("full_req", int'(tb_req), 1);
        step(0, 0, '0, 0, 0, 0);
        cmp("full_req_off", int'(tb_req), 0);
        step(0, 1, rvec(), 0, 0, 0);
        cmp("w41_ptr", int'(wr_ptr), 0);
        cmp("w41_fill", int'(fill), 40);
        cmp("w41_req", int'(tb_req), 1);

        // Same-column read and write: old bit 3 = 0, new bit 3 = 1.
        step(0, 1, 64'h0, 1, 0, 0);
        step(0, 1, rvec(), 0, 0, 0);
        v = 64'h8; step(0, 1, v, 1, 0, 3);
`ifdef SURVMEM_RAW_FWD_EN
        cmp("raw_fwd", int'(tb_surv_bit), 1);
`else
        cmp("raw_nofwd", int'(tb_surv_bit), 0);
`endif

        // frame_start with a write at wr_ptr = 22.
        step(1, 0, '0, 0, 0, 0);
        for (int i = 0; i < 23; i++) step(0, 1, rvec(), 0, 0, 0);
        cmp("fs_pre_ptr", int'(wr_ptr), 22);
        step(0, 1, rvec(), 1, 0, 0);
        cmp("fs_ptr", int'(wr_ptr), 0);
        cmp("fs_fill", int'(fill), 1);
        cmp("fs_req", int'(tb_req), 0);

        // Reset while full and writing.
        for (int i = 0; i < 45; i++) step(0, 1, rvec(), 0, i % D, i);
        step(1, 1, rvec(), 0, 3, 3);
        cmp("rstf_ptr", int'(wr_ptr), 39);
        cmp("rstf_fill", int'(fill), 0);
        cmp("rstf_req", int'(tb_req), 0);
        cmp("rstf_surv", int'(tb_surv_bit), 0);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 9) < 7),
                 rvec(),
                 ($urandom_range(0, 59) == 0),
                 $urandom_range(0, 47),
                 $urandom_range(0, NS - 1));
        end
        step(0, 0, '0, 0, 0, 0);
        repeat (2) @(negedge clk);
        if (sb_q.size() != 0) cmp("sb_drain", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
